mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/lc3b_types.sv | 19 +
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b bus types, plus the memory arbiter's FSM state and grant-id types.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        StIdle,
        StInstBusy,
        StDataBusy,
        StDone
    } arb_state_t;

    typedef enum logic {
        GrantInst,
        GrantData
    } arb_grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single physical memory port.
// One transaction at a time. Contention is resolved in favour of the port that
// was not granted last. A DONE bubble follows every completion.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter bit INST_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          inst_mem_read,
    input  logic          inst_mem_write,
    input  lc3b_mem_wmask inst_mem_byte_enable,
    input  lc3b_word      inst_mem_addr,
    input  lc3b_word      inst_mem_wdata,
    output lc3b_word      inst_mem_rdata,
    output logic          inst_mem_resp,

    input  logic          data_mem_read,
    input  logic          data_mem_write,
    input  lc3b_mem_wmask data_mem_byte_enable,
    input  lc3b_word      data_mem_addr,
    input  lc3b_word      data_mem_wdata,
    output lc3b_word      data_mem_rdata,
    output logic          data_mem_resp,

    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_mem_wmask pmem_wmask,
    output lc3b_word      pmem_address,
    output lc3b_word      pmem_wdata,
    input  lc3b_word      pmem_rdata,
    input  logic          pmem_resp
);

    // Reset value makes the first contended grant go to the preferred port.
    localparam arb_grant_t ResetGrant = arb_grant_t'(INST_FIRST ? GrantData : GrantInst);

    arb_state_t    state_q, state_d;
    arb_grant_t    last_grant_q, last_grant_d;
    lc3b_word      req_addr_q, req_addr_d;
    lc3b_word      req_wdata_q, req_wdata_d;
    lc3b_mem_wmask req_wmask_q, req_wmask_d;
    logic          req_write_q, req_write_d;
    lc3b_word      inst_rdata_q, data_rdata_q;

    logic inst_pending, data_pending;
    logic grant_inst, grant_data;
    logic busy;

    assign inst_pending = inst_mem_read | inst_mem_write;
    assign data_pending = data_mem_read | data_mem_write;

    // Arbitration, payload latching on grant, and FSM next state.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_wmask_d  = req_wmask_q;
        req_write_d  = req_write_q;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (inst_pending && data_pending) begin
                    grant_inst = (last_grant_q == GrantData);
                    grant_data = (last_grant_q == GrantInst);
                end else begin
                    grant_inst = inst_pending;
                    grant_data = data_pending;
                end

                // Read+write together is treated as a write.
                if (grant_inst) begin
                    state_d      = StInstBusy;
                    last_grant_d = GrantInst;
                    req_addr_d   = inst_mem_addr;
                    req_wdata_d  = inst_mem_wdata;
                    req_wmask_d  = inst_mem_byte_enable;
                    req_write_d  = inst_mem_write;
                end else if (grant_data) begin
                    state_d      = StDataBusy;
                    last_grant_d = GrantData;
                    req_addr_d   = data_mem_addr;
                    req_wdata_d  = data_mem_wdata;
                    req_wmask_d  = data_mem_byte_enable;
                    req_write_d  = data_mem_write;
                end
            end
            StInstBusy, StDataBusy: begin
                if (pmem_resp) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Bubble so the client can drop its strobe before re-arbitration.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, grant history, latched request and per-port read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= ResetGrant;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_wmask_q  <= '0;
            req_write_q  <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_wmask_q  <= req_wmask_d;
            req_write_q  <= req_write_d;
            if (inst_mem_resp) begin
                inst_rdata_q <= pmem_rdata;
            end
            if (data_mem_resp) begin
                data_rdata_q <= pmem_rdata;
            end
        end
    end

    // Physical-port strobes come only from the latched request; responses pass straight through.
    assign busy           = (state_q == StInstBusy) || (state_q == StDataBusy);
    assign pmem_read      = busy & ~req_write_q;
    assign pmem_write     = busy & req_write_q;
    assign pmem_address   = req_addr_q;
    assign pmem_wdata     = req_wdata_q;
    assign pmem_wmask     = req_wmask_q;

    assign inst_mem_resp  = (state_q == StInstBusy) & pmem_resp;
    assign data_mem_resp  = (state_q == StDataBusy) & pmem_resp;
    assign inst_mem_rdata = inst_mem_resp ? pmem_rdata : inst_rdata_q;
    assign data_mem_rdata = data_mem_resp ? pmem_rdata : data_rdata_q;

endmodule
